// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int FIFO_W  = 57;
    localparam int TAG_W   = 2;
    localparam int MAX_SRC = 4;

    typedef enum logic {IDLE, GRANT} state_t;

    typedef struct packed {
        logic             found;
        logic [TAG_W-1:0] idx;
    } pick_t;

    // Search starts one above 'last' and wraps; 'last' itself is tried last.
    function automatic pick_t rr_pick(input logic [MAX_SRC-1:0] mask,
                                      input logic [TAG_W-1:0]   last,
                                      input int unsigned        n);
        pick_t       p;
        int unsigned cand;
        logic [TAG_W-1:0] cand_idx;
        p = '0;
        for (int unsigned k = 1; k <= MAX_SRC; k++) begin
            cand = 32'(last) + k;
            if (cand >= n) cand = cand - n;
            cand_idx = cand[TAG_W-1:0];
            if (k <= n && !p.found && mask[cand_idx]) begin
                p.found = 1'b1;
                p.idx   = cand_idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// Round-robin priority pick over the requester vector.
// Latency: purely combinational.
// Backpressure: none; consumer decides whether to act on the pick.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [TAG_W-1:0] start,
    output logic             found,
    output logic [TAG_W-1:0] idx
);

    pick_t p;

    always_comb begin
        p     = rr_pick(MAX_SRC'(req), start, unsigned'(N_SRC));
        found = p.found;
        idx   = p.idx;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one tagged FIFO write port among N_SRC sources.
// Latency: 1 cycle arbitration from IDLE, zero from accept to FIFO write.
// Backpressure: fifo_wrfull drops src_ready/fifo_wrreq combinationally; grant is held.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 55,
    parameter int BURST_MAX = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_SRC-1:0]        src_mask,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]        src_ready,
    output logic [FIFO_W-1:0]       fifo_data,
    output logic                    fifo_wrreq,
    input  logic                    fifo_wrfull,
    output logic [TAG_W-1:0]        cur_grant,
    output logic                    busy,
    output logic [31:0]             word_cnt,
    output logic [15:0]             stall_cnt
);

    state_t           state, state_nxt;
    logic [TAG_W-1:0] grant, grant_nxt;
    logic [TAG_W-1:0] last_grant, last_grant_nxt;
    logic [7:0]       burst_cnt, burst_nxt;

    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] grant_onehot;
    logic [N_SRC-1:0] pick_req;
    logic [TAG_W-1:0] pick_start;
    logic [TAG_W-1:0] pick_idx;
    logic             pick_found;
    logic             g_valid, g_mask;
    logic             wr, burst_end, release_g, stall;
    logic [DATA_W-1:0] g_payload;

    always_comb begin
        eligible     = enable ? (src_valid & src_mask) : '0;
        grant_onehot = N_SRC'(1) << grant;
        g_valid      = src_valid[grant];
        g_mask       = src_mask[grant];
        wr           = (state == GRANT) & g_valid & g_mask & enable & ~fifo_wrfull & ~reset;
        burst_end    = wr & (burst_cnt == 8'(BURST_MAX - 1));
        release_g    = (state == GRANT) & (~g_valid | ~g_mask | ~enable | burst_end);
        stall        = (state == GRANT) & g_valid & fifo_wrfull;
        // An expired burst must not be re-granted immediately to the same source.
        pick_req     = burst_end ? (eligible & ~grant_onehot) : eligible;
        pick_start   = (state == GRANT) ? grant : last_grant;
        g_payload    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant == TAG_W'(i)) g_payload = src_data[i*DATA_W +: DATA_W];
        end
    end

    rr_priority_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .req   (pick_req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= TAG_W'(N_SRC - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            burst_cnt  <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        burst_nxt      = wr ? burst_cnt + 8'd1 : burst_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    grant_nxt = pick_idx;
                    burst_nxt = '0;
                end
            end
            GRANT: begin
                if (release_g) begin
                    last_grant_nxt = grant;
                    if (pick_found) begin
                        grant_nxt = pick_idx;
                        burst_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src_ready  = wr ? grant_onehot : '0;
        fifo_wrreq = wr;
        fifo_data  = wr ? {grant, g_payload} : '0;
        busy       = (state == GRANT);
        cur_grant  = grant;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (wr) word_cnt <= word_cnt + 32'd1;
            if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (BURST_MAX = 4, four sources).
module tb_fifo_wr_arbiter;

    localparam int NS = 4;
    localparam int DW = 55;
    localparam int BM = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic [NS-1:0]   src_mask;
    logic [NS-1:0]   src_valid;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]   src_ready;
    logic [56:0]     fifo_data;
    logic            fifo_wrreq;
    logic            fifo_wrfull;
    logic [1:0]      cur_grant;
    logic            busy;
    logic [31:0]     word_cnt;
    logic [15:0]     stall_cnt;

    fifo_wr_arbiter #(
        .N_SRC     (NS),
        .DATA_W    (DW),
        .BURST_MAX (BM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .src_mask    (src_mask),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .fifo_data   (fifo_data),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_wrfull (fifo_wrfull),
        .cur_grant   (cur_grant),
        .busy        (busy),
        .word_cnt    (word_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [54:0] base [NS];
    int          seq  [NS];
    logic [56:0] sb [$];

    always_comb begin
        for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = base[i] + 55'(seq[i]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int s, input int first, input int n);
        for (int k = 0; k < n; k++) sb.push_back({2'(s), base[s] + 55'(first + k)});
    endtask

    // Check the current cycle at the falling edge, then advance past the next rising edge.
    task automatic cyc(input int n);
        logic [NS-1:0] acc;
        logic [56:0]   exp;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            acc = '0;
            if (reset) begin
                chk("wrreq_in_reset", 64'(fifo_wrreq), 64'd0);
            end else if (fifo_wrreq) begin
                chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    chk("fifo_data", 64'(fifo_data), 64'(exp));
                    chk("ready_onehot", 64'(src_ready), 64'(4'(1) << exp[56:55]));
                end
                acc = src_valid & src_ready;
            end else begin
                chk("ready_no_write", 64'(src_ready), 64'd0);
            end
            @(posedge clock);
            #1;
            for (int i = 0; i < NS; i++) if (acc[i]) seq[i]++;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        enable      = 1'b1;
        src_mask    = '1;
        src_valid   = '0;
        fifo_wrfull = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            base[i] = 55'(i + 1) << 16;
            seq[i]  = 0;
        end

        // Reset state
        do_reset();
        chk("rst_ready", 64'(src_ready), 64'd0);
        chk("rst_wrreq", 64'(fifo_wrreq), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(cur_grant), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Single source 2, payload 0x1234
        base[2] = 55'h1234;
        seq[2]  = 0;
        sb.push_back({2'd2, 55'h1234});
        src_valid = 4'b0100;
        cyc(1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_grant", 64'(cur_grant), 64'd2);
        chk("t1_wrreq", 64'(fifo_wrreq), 64'd1);
        chk("t1_ready", 64'(src_ready), 64'b0100);
        chk("t1_data", 64'(fifo_data), 64'({2'd2, 55'h1234}));
        cyc(1);
        src_valid = '0;
        chk("t1_word_cnt", 64'(word_cnt), 64'd1);
        cyc(1);
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        base[2] = 55'(3) << 16;

        // All sources valid: order 0,1,2,3,0 with 4-word bursts
        do_reset();
        for (int s = 0; s < NS; s++) push_burst(s, seq[s], BM);
        push_burst(0, seq[0] + BM, 1);
        src_valid = 4'hF;
        cyc(17);
        chk("t2_word_cnt", 64'(word_cnt), 64'd16);
        chk("t2_regrant0", 64'(cur_grant), 64'd0);
        cyc(1);
        src_valid = '0;
        cyc(2);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);
        chk("t2_idle", 64'(busy), 64'd0);

        // wrfull for 5 cycles mid-burst on source 1, source 3 waiting
        do_reset();
        push_burst(1, seq[1], BM);
        push_burst(3, seq[3], BM);
        src_valid = 4'b1010;
        cyc(3);
        fifo_wrfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("t3_hold_grant", 64'(cur_grant), 64'd1);
        end
        chk("t3_stall_cnt", 64'(stall_cnt), 64'd5);
        chk("t3_word_cnt_frozen", 64'(word_cnt), 64'd2);
        fifo_wrfull = 1'b0;
        cyc(6);
        src_valid = '0;
        cyc(2);
        chk("t3_word_cnt", 64'(word_cnt), 64'd8);
        chk("t3_stall_kept", 64'(stall_cnt), 64'd5);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Source 0 drops valid after 2 words; source 3 takes over without idling
        do_reset();
        push_burst(0, seq[0], 2);
        push_burst(3, seq[3], 2);
        src_valid = 4'b1001;
        cyc(3);
        src_valid[0] = 1'b0;
        cyc(1);
        chk("t4_grant3", 64'(cur_grant), 64'd3);
        chk("t4_busy", 64'(busy), 64'd1);
        cyc(2);
        src_valid = '0;
        cyc(2);
        chk("t4_word_cnt", 64'(word_cnt), 64'd4);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Mask removal moves the grant, then to IDLE when nothing is eligible
        do_reset();
        push_burst(1, seq[1], 1);
        push_burst(2, seq[2], 2);
        src_valid = 4'b0110;
        cyc(2);
        src_mask = 4'b1101;
        cyc(1);
        chk("t5_grant2", 64'(cur_grant), 64'd2);
        cyc(2);
        src_mask = 4'b1001;
        cyc(1);
        chk("t5_idle", 64'(busy), 64'd0);
        cyc(2);
        chk("t5_word_cnt", 64'(word_cnt), 64'd3);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        src_valid = '0;
        src_mask  = '1;

        // Reset mid-burst
        do_reset();
        push_burst(0, seq[0], 2);
        src_valid = 4'hF;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t6_word_cnt", 64'(word_cnt), 64'd0);
        chk("t6_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_grant", 64'(cur_grant), 64'd0);
        push_burst(0, seq[0], 1);
        cyc(2);
        chk("t6_first_grant", 64'(cur_grant), 64'd0);
        src_valid = '0;
        cyc(2);
        chk("t6_word_cnt_after", 64'(word_cnt), 64'd1);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
